// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// Pipeline register between the decode (ID) and execute (EX) stages of a
// five-stage MIPS-style pipeline. It includes load-use hazard detection and a
// bubble counter.
//
// Each rising clk edge applies the first matching case, in this order:
//   1. flush   : the instruction in decode is squashed. All Ex registers are
//                cleared and a bubble is counted.
//   2. stallId : a load-use hazard. The control registers and validEx are
//                cleared, so a bubble goes down the pipe. The data and field
//                registers keep their values. Decode holds its instruction
//                because stallId also freezes the PC and IF/ID.
//   3. load    : every Ex register captures its decode-stage input. The
//                immediate is sign-extended and validEx is set.
//
// Ports
//   clk, reset          single clock; asynchronous active-high reset
//   flush               squash decode (taken branch / jump)
//   readData1/2         register-file operands (32b)
//   immediate           instruction[15:0]
//   rs, rt, rd          instruction[25:21], [20:16], [15:11]
//   pcPlus4             PC + 4 of the decode instruction
//   *In control         regWrite, memRead, memWrite, memToReg, aluSrc,
//                       regDst (1b each), aluOp (2b)
//   *Ex outputs         registered copies of the above; immExtEx is the
//                       sign-extended immediate
//   validEx             EX holds a real instruction, not a bubble
//   stallId             combinational hold request to the PC and IF/ID
//   bubbleCount         bubbles inserted (flush or stall). It saturates.
// ---------------------------------------------------------------------------
module id_ex_register #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [31:0]            readData1,
  input  logic [31:0]            readData2,
  input  logic [15:0]            immediate,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic [4:0]             rd,
  input  logic [31:0]            pcPlus4,
  input  logic                   regWriteIn,
  input  logic                   memReadIn,
  input  logic                   memWriteIn,
  input  logic                   memToRegIn,
  input  logic                   aluSrcIn,
  input  logic                   regDstIn,
  input  logic [1:0]             aluOpIn,
  output logic [31:0]            readData1Ex,
  output logic [31:0]            readData2Ex,
  output logic [31:0]            immExtEx,
  output logic [31:0]            pcPlus4Ex,
  output logic [4:0]             rsEx,
  output logic [4:0]             rtEx,
  output logic [4:0]             rdEx,
  output logic                   regWriteEx,
  output logic                   memReadEx,
  output logic                   memWriteEx,
  output logic                   memToRegEx,
  output logic                   aluSrcEx,
  output logic                   regDstEx,
  output logic [1:0]             aluOpEx,
  output logic                   validEx,
  output logic                   stallId,
  output logic [COUNT_WIDTH-1:0] bubbleCount
);

  // -------------------------------------------------------------------------
  // Load-use hazard detection
  // -------------------------------------------------------------------------
  // A load in EX whose destination (rt) is a source of the decode
  // instruction must wait one cycle. Register 0 is hard-wired to zero, so it
  // never creates a dependency. This logic uses only registered state and
  // the current inputs. During reset validEx and memReadEx are 0, so stallId
  // is 0 with no further gating.
  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  assign rt_nonzero = (rtEx != 5'd0);
  assign rs_match   = (rtEx == rs);
  assign rt_match   = (rtEx == rt);
  assign stallId    = validEx & memReadEx & rt_nonzero & (rs_match | rt_match);

  // -------------------------------------------------------------------------
  // Case selection
  // -------------------------------------------------------------------------
  // Flush takes priority. When flush and stall are both active, only one
  // bubble is counted.
  logic do_flush;
  logic do_stall;
  logic do_bubble;

  assign do_flush  = flush;
  assign do_stall  = ~flush & stallId;
  assign do_bubble = do_flush | do_stall;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [31:0]            read_data1_next;
  logic [31:0]            read_data2_next;
  logic [31:0]            imm_ext_next;
  logic [31:0]            pc_plus4_next;
  logic [4:0]             rs_next;
  logic [4:0]             rt_next;
  logic [4:0]             rd_next;
  logic                   reg_write_next;
  logic                   mem_read_next;
  logic                   mem_write_next;
  logic                   mem_to_reg_next;
  logic                   alu_src_next;
  logic                   reg_dst_next;
  logic [1:0]             alu_op_next;
  logic                   valid_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   count_full;

  // Data and field path. Zero on flush, hold on stall, load otherwise.
  always_comb begin
    read_data1_next = readData1;
    read_data2_next = readData2;
    imm_ext_next    = {{16{immediate[15]}}, immediate};
    pc_plus4_next   = pcPlus4;
    rs_next         = rs;
    rt_next         = rt;
    rd_next         = rd;
    if (do_flush) begin
      read_data1_next = '0;
      read_data2_next = '0;
      imm_ext_next    = '0;
      pc_plus4_next   = '0;
      rs_next         = '0;
      rt_next         = '0;
      rd_next         = '0;
    end else if (do_stall) begin
      read_data1_next = readData1Ex;
      read_data2_next = readData2Ex;
      imm_ext_next    = immExtEx;
      pc_plus4_next   = pcPlus4Ex;
      rs_next         = rsEx;
      rt_next         = rtEx;
      rd_next         = rdEx;
    end
  end

  // Control path. Any bubble clears every enable, so a bubble cannot write
  // registers or memory downstream. Clearing memReadEx also ends the stall
  // after exactly one cycle.
  always_comb begin
    reg_write_next  = regWriteIn;
    mem_read_next   = memReadIn;
    mem_write_next  = memWriteIn;
    mem_to_reg_next = memToRegIn;
    alu_src_next    = aluSrcIn;
    reg_dst_next    = regDstIn;
    alu_op_next     = aluOpIn;
    valid_next      = 1'b1;
    if (do_bubble) begin
      reg_write_next  = 1'b0;
      mem_read_next   = 1'b0;
      mem_write_next  = 1'b0;
      mem_to_reg_next = 1'b0;
      alu_src_next    = 1'b0;
      reg_dst_next    = 1'b0;
      alu_op_next     = 2'b00;
      valid_next      = 1'b0;
    end
  end

  // Bubble counter. It saturates at all-ones and does not wrap.
  assign count_full = &bubbleCount;

  always_comb begin
    count_next = bubbleCount;
    if (do_bubble && !count_full) begin
      count_next = bubbleCount + COUNT_WIDTH'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData1Ex <= '0;
      readData2Ex <= '0;
      immExtEx    <= '0;
      pcPlus4Ex   <= '0;
      rsEx        <= '0;
      rtEx        <= '0;
      rdEx        <= '0;
      regWriteEx  <= 1'b0;
      memReadEx   <= 1'b0;
      memWriteEx  <= 1'b0;
      memToRegEx  <= 1'b0;
      aluSrcEx    <= 1'b0;
      regDstEx    <= 1'b0;
      aluOpEx     <= 2'b00;
      validEx     <= 1'b0;
      bubbleCount <= '0;
    end else begin
      readData1Ex <= read_data1_next;
      readData2Ex <= read_data2_next;
      immExtEx    <= imm_ext_next;
      pcPlus4Ex   <= pc_plus4_next;
      rsEx        <= rs_next;
      rtEx        <= rt_next;
      rdEx        <= rd_next;
      regWriteEx  <= reg_write_next;
      memReadEx   <= mem_read_next;
      memWriteEx  <= mem_write_next;
      memToRegEx  <= mem_to_reg_next;
      aluSrcEx    <= alu_src_next;
      regDstEx    <= reg_dst_next;
      aluOpEx     <= alu_op_next;
      validEx     <= valid_next;
      bubbleCount <= count_next;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Testbench for id_ex_register. The stimulus pushes one expected record per
// clock cycle. The monitor samples stallId before the edge and the
// registered state after the edge, then compares both with the record. A
// second instance with COUNT_WIDTH=4 checks saturation of the bubble counter.
module tb_id_ex_register;

  localparam int LOAD   = 0;
  localparam int BUBBLE = 1;
  localparam int FLUSH  = 2;

  // control byte: [7]regWrite [6]memRead [5]memWrite [4]memToReg
  //               [3]aluSrc   [2]regDst  [1:0]aluOp
  localparam logic [7:0] C_LW  = 8'hD8;
  localparam logic [7:0] C_R   = 8'h86;
  localparam logic [7:0] C_RW  = 8'h80;
  localparam logic [7:0] C_SW  = 8'h28;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } in_t;

  typedef struct {
    string        name;
    logic [167:0] st;
    logic         stall;
    logic [3:0]   sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush, flush_s;
  logic [31:0] readData1, readData2, pcPlus4;
  logic [15:0] immediate;
  logic [4:0]  rs, rt, rd;
  logic regWriteIn, memReadIn, memWriteIn, memToRegIn, aluSrcIn, regDstIn;
  logic [1:0] aluOpIn;

  logic [31:0] readData1Ex, readData2Ex, immExtEx, pcPlus4Ex;
  logic [4:0]  rsEx, rtEx, rdEx;
  logic regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx, regDstEx;
  logic [1:0]  aluOpEx;
  logic validEx, stallId;
  logic [15:0] bubbleCount;

  logic [31:0] s_rd1, s_rd2, s_imm, s_pc;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic s_rw, s_mr, s_mw, s_m2r, s_src, s_dst, s_valid, s_stall;
  logic [1:0]  s_op;
  logic [3:0]  s_count;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [167:0] prev_st;
  logic [3:0]   sat_model;

  always #5 clk = ~clk;

  id_ex_register #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .readData1(readData1), .readData2(readData2), .immediate(immediate),
    .rs(rs), .rt(rt), .rd(rd), .pcPlus4(pcPlus4),
    .regWriteIn(regWriteIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .memToRegIn(memToRegIn), .aluSrcIn(aluSrcIn), .regDstIn(regDstIn),
    .aluOpIn(aluOpIn),
    .readData1Ex(readData1Ex), .readData2Ex(readData2Ex), .immExtEx(immExtEx),
    .pcPlus4Ex(pcPlus4Ex), .rsEx(rsEx), .rtEx(rtEx), .rdEx(rdEx),
    .regWriteEx(regWriteEx), .memReadEx(memReadEx), .memWriteEx(memWriteEx),
    .memToRegEx(memToRegEx), .aluSrcEx(aluSrcEx), .regDstEx(regDstEx),
    .aluOpEx(aluOpEx), .validEx(validEx), .stallId(stallId),
    .bubbleCount(bubbleCount)
  );

  // Saturation instance: only flush_s toggles, so it can never stall.
  id_ex_register #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush_s),
    .readData1(32'h0), .readData2(32'h0), .immediate(16'h0),
    .rs(5'd0), .rt(5'd0), .rd(5'd0), .pcPlus4(32'h0),
    .regWriteIn(1'b0), .memReadIn(1'b0), .memWriteIn(1'b0),
    .memToRegIn(1'b0), .aluSrcIn(1'b0), .regDstIn(1'b0), .aluOpIn(2'b00),
    .readData1Ex(s_rd1), .readData2Ex(s_rd2), .immExtEx(s_imm),
    .pcPlus4Ex(s_pc), .rsEx(s_rs), .rtEx(s_rt), .rdEx(s_rd),
    .regWriteEx(s_rw), .memReadEx(s_mr), .memWriteEx(s_mw),
    .memToRegEx(s_m2r), .aluSrcEx(s_src), .regDstEx(s_dst),
    .aluOpEx(s_op), .validEx(s_valid), .stallId(s_stall),
    .bubbleCount(s_count)
  );

  logic [167:0] act_st;
  assign act_st = {readData1Ex, readData2Ex, immExtEx, pcPlus4Ex, rsEx, rtEx, rdEx,
                   regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx,
                   regDstEx, aluOpEx, validEx, bubbleCount};

  task automatic check(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [15:0] imm, input logic [31:0] pc,
                             input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [7:0] ctrl);
    in_t i;
    i.rd1 = rd1; i.rd2 = rd2; i.imm = imm; i.pc = pc;
    i.rs = a; i.rt = b; i.rd = c; i.ctrl = ctrl;
    return i;
  endfunction

  task automatic drive(input in_t i);
    readData1 = i.rd1; readData2 = i.rd2; immediate = i.imm; pcPlus4 = i.pc;
    rs = i.rs; rt = i.rt; rd = i.rd;
    {regWriteIn, memReadIn, memWriteIn, memToRegIn, aluSrcIn, regDstIn, aluOpIn} = i.ctrl;
  endtask

  // One clock cycle: drive the inputs, queue the expected result, wait for the edge.
  task automatic step(input string nm, input in_t i, input logic fl, input logic fls,
                      input int kind, input logic exp_stall, input logic [15:0] exp_cnt);
    exp_t e;
    drive(i);
    flush   = fl;
    flush_s = fls;
    case (kind)
      LOAD:    e.st = {i.rd1, i.rd2, {{16{i.imm[15]}}, i.imm}, i.pc, i.rs, i.rt, i.rd,
                       i.ctrl, 1'b1, exp_cnt};
      BUBBLE:  e.st = {prev_st[167:25], 8'h00, 1'b0, exp_cnt};
      default: e.st = {143'd0, 8'h00, 1'b0, exp_cnt};
    endcase
    if (fls && sat_model != 4'hF) sat_model = sat_model + 4'd1;
    e.name  = nm;
    e.stall = exp_stall;
    e.sat   = sat_model;
    q.push_back(e);
    prev_st = e.st;
    @(posedge clk);
    #2;
  endtask

  // Monitor: the stall is sampled before the edge, the state after it.
  initial begin
    exp_t e;
    logic st_act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        st_act = stallId;
        @(posedge clk);
        #1;
        $display("txn %-18s stall=%0b valid=%0b cnt=%0d sat=%0d", e.name, st_act, validEx,
                 bubbleCount, s_count);
        check({e.name, ".stall"}, {167'd0, st_act}, {167'd0, e.stall});
        check({e.name, ".state"}, act_st, e.st);
        check({e.name, ".sat"}, {164'd0, s_count}, {164'd0, e.sat});
      end
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    in_t idle;
    int w;
    sat_model = 4'd0;
    prev_st   = '0;
    reset = 1'b1; flush = 1'b0; flush_s = 1'b0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(idle);
    #2;
    check("reset_state", act_st, '0);
    check("reset_stall", {167'd0, stallId}, '0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    step("norm_load",      mk(32'h5, 32'h11, 16'h8001, 32'h100, 1, 2, 3, C_RW), 0, 0, LOAD, 0, 0);
    check("norm_imm", {136'd0, immExtEx}, {136'd0, 32'hFFFF_8001});
    step("lw_r8",          mk(32'h20, 32'h21, 16'h0010, 32'h104, 4, 8, 0, C_LW), 0, 0, LOAD, 0, 0);
    step("use_r8_stall",   mk(32'h30, 32'h31, 16'h0000, 32'h108, 8, 9, 10, C_R), 0, 0, BUBBLE, 1, 1);
    step("use_r8_go",      mk(32'h30, 32'h31, 16'h0000, 32'h108, 8, 9, 10, C_R), 0, 0, LOAD, 0, 1);
    step("lw_r0",          mk(32'h40, 32'h41, 16'hFFFC, 32'h10C, 5, 0, 0, C_LW), 0, 0, LOAD, 0, 1);
    step("use_r0",         mk(32'h50, 32'h51, 16'h0000, 32'h110, 0, 0, 11, C_R), 0, 0, LOAD, 0, 1);
    step("lw_r8b",         mk(32'h60, 32'h61, 16'h7FFF, 32'h114, 1, 8, 0, C_LW), 0, 0, LOAD, 0, 1);
    step("no_dep_r9_r10",  mk(32'h70, 32'h71, 16'h0000, 32'h118, 9, 10, 11, C_R), 0, 0, LOAD, 0, 1);
    step("lw_r7",          mk(32'h80, 32'h81, 16'h0004, 32'h11C, 2, 7, 0, C_LW), 0, 0, LOAD, 0, 1);
    step("use_rt7_stall",  mk(32'h90, 32'h91, 16'h0008, 32'h120, 1, 7, 3, C_SW), 0, 0, BUBBLE, 1, 2);
    step("use_rt7_go",     mk(32'h90, 32'h91, 16'h0008, 32'h120, 1, 7, 3, C_SW), 0, 0, LOAD, 0, 2);
    step("lw_r12",         mk(32'hA0, 32'hA1, 16'h0000, 32'h124, 3, 12, 0, C_LW), 0, 0, LOAD, 0, 2);
    step("flush_and_stall",mk(32'hB0, 32'hB1, 16'h1234, 32'h128, 12, 0, 4, C_R), 1, 0, FLUSH, 1, 3);
    step("after_flush",    mk(32'hB0, 32'hB1, 16'h1234, 32'h128, 12, 0, 4, C_R), 0, 0, LOAD, 0, 3);
    step("flush_only",     mk(32'hC0, 32'hC1, 16'h5555, 32'h12C, 6, 7, 8, C_R), 1, 0, FLUSH, 0, 4);
    step("load_after",     mk(32'hD0, 32'hD1, 16'hAAAA, 32'h130, 6, 7, 8, C_R), 0, 0, LOAD, 0, 4);

    for (int i = 0; i < 20; i++)
      step($sformatf("sat_flush_%0d", i), mk(i, 0, 16'(i), 0, 0, 0, 0, C_RW), 0, 1, LOAD, 0, 4);
    step("sat_hold", mk(32'hE0, 0, 0, 0, 0, 0, 0, C_RW), 0, 0, LOAD, 0, 4);

    // Reset arrives between edges while EX holds a valid load and stallId is high.
    step("lw_pre_reset",   mk(32'hF0, 32'hF1, 16'h0020, 32'h200, 1, 8, 0, C_LW), 0, 0, LOAD, 0, 4);
    drive(mk(32'hF4, 32'hF5, 0, 32'h204, 8, 2, 3, C_R));
    #1;
    check("pre_reset_stall", {167'd0, stallId}, {167'd0, 1'b1});
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_state", act_st, '0);
    check("async_reset_stall", {167'd0, stallId}, '0);
    check("async_reset_sat", {164'd0, s_count}, '0);
    @(posedge clk);
    #2;
    check("reset_held_state", act_st, '0);
    reset = 1'b0;
    sat_model = 4'd0;
    prev_st   = '0;
    step("first_after_reset", mk(32'h1, 32'h2, 16'h0003, 32'h300, 8, 2, 3, C_R), 0, 0, LOAD, 0, 0);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #3;
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 The module SHALL expose parameter COUNT_WIDTH, default 16, giving the width of the bubble counter.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-004 The module SHALL have port flush, input, 1 bit, which squashes the instruction in decode (taken branch/jump).
REQ-005 The module SHALL have ports readData1 and readData2, input, 32 bits each, the decode-stage register-file operands.
REQ-006 The module SHALL have port immediate, input, 16 bits, which is instruction bits 15:0.
REQ-007 The module SHALL have ports rs, rt and rd, input, 5 bits each, which are instruction fields 25:21, 20:16 and 15:11.
REQ-008 The module SHALL have port pcPlus4, input, 32 bits.
REQ-009 The module SHALL have control ports regWriteIn, memReadIn, memWriteIn, memToRegIn, aluSrcIn and regDstIn, input, 1 bit each, plus aluOpIn, input, 2 bits.
REQ-010 The module SHALL have registered outputs readData1Ex, readData2Ex, immExtEx and pcPlus4Ex, 32 bits each; rsEx, rtEx and rdEx, 5 bits each; the seven control signals with suffix Ex at matching widths; and validEx, 1 bit.
REQ-011 The module SHALL have port stallId, output, 1 bit, a combinational hold request to the PC and IF/ID registers.
REQ-012 The module SHALL have port bubbleCount, output, COUNT_WIDTH bits, the number of bubbles inserted.

Function
REQ-013 stallId SHALL equal validEx AND memReadEx AND (rtEx != 0) AND (rtEx == rs OR rtEx == rt), derived only from registered state and current inputs.
REQ-014 Each rising edge SHALL apply the first matching case in this priority order: flush, then stallId, then normal load.
REQ-015 On a normal load, every Ex register SHALL capture its input, immExtEx SHALL be the sign-extension of immediate, and validEx SHALL be 1.
REQ-016 On a flush, all control Ex outputs and validEx SHALL be 0, and all data and field Ex outputs SHALL be 0.
REQ-017 On a stall, all control Ex outputs and validEx SHALL be 0, and the data and field Ex registers SHALL hold their values.
REQ-018 A stall SHALL last exactly one cycle per load-use hazard, because the inserted bubble clears memReadEx.
REQ-019 When flush and stallId are both asserted in the same cycle, the flush case SHALL apply and bubbleCount SHALL increment once.
REQ-020 bubbleCount SHALL increment by 1 on every edge that applies the flush case or the stall case, and SHALL saturate at all-ones without wrapping.
REQ-021 A hazard on register 0 (rtEx == 0) SHALL never stall.
REQ-022 Bubble cycles SHALL produce no write-enable or memory side effects downstream, because regWriteEx and memWriteEx are 0.

Reset
REQ-023 While reset is high, all Ex outputs, validEx and bubbleCount SHALL be 0 immediately, independent of clk.
REQ-024 Because memReadEx and validEx are 0 during reset, stallId SHALL be 0 during reset.
REQ-025 On the first rising edge after reset deasserts, the flush/stall/normal priority of REQ-014 SHALL apply.
REQ-026 When reset asserts mid-stall, the pending bubble SHALL be discarded and stallId SHALL drop to 0 within the same cycle.

Verification
REQ-027 Normal load: readData1=0x0000_0005, immediate=0x8001, regWriteIn=1, one edge -> readData1Ex=5, immExtEx=0xFFFF_8001, regWriteEx=1, validEx=1.
REQ-028 Load-use: load lw with rt=8; next instruction has rs=8 -> stallId=1 for one cycle, then a bubble with validEx=0 and memReadEx=0, decode holds, stallId=0 on the following cycle, bubbleCount=1.
REQ-029 No false stall: lw with rt=0 followed by an instruction with rs=0 -> stallId stays 0; lw with rt=8 followed by rs=9, rt=10 -> no stall.
REQ-030 Flush priority: flush=1 in the same cycle as stallId=1 -> all Ex outputs are 0 after the edge and bubbleCount increments by exactly 1.
REQ-031 Saturation: with COUNT_WIDTH=4, apply 20 consecutive flush cycles -> bubbleCount=0xF and it stays there.
REQ-032 Asynchronous reset: assert reset between clock edges while validEx=1 -> all outputs read 0 before the next edge; the first normal load after release gives validEx=1.
